// File: rtl/cv32e40p_hwlp_unit.sv
// ---------------------------------------------------------------------------
// cv32e40p_hwlp_unit
//
// Hardware-loop unit. Holds start/end/count registers for N_HWLP zero-overhead
// loops, watches the ID-stage PC for loop-end hits, decrements the count of the
// serviced loop and issues a registered branch-to-start request that is held
// until the prefetcher acknowledges it.
//
// Optional feature macro: CV32E40P_HWLP_ERR_CHECK_EN
//   defined   -> err_o flags bad loop bounds and improper nesting (sticky)
//   undefined -> err_o is tied to 0
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   we_i         write strobes: bit0 start, bit1 end, bit2 count
//   regid_i      index of the loop being written
//   wdata_i      write data
//   pc_id_i      PC of the instruction in ID
//   id_valid_i   ID instruction retires this cycle
//   jump_ack_i   prefetcher accepts the pending jump
//   jump_o       loop-back jump pending
//   target_o     jump target (loop start)
//   stall_o      ID must not advance (equals jump_o)
//   start_o      start registers, for CSR read
//   end_o        end registers, for CSR read
//   cnt_o        count registers, for CSR read
//   err_o        loop configuration error
// ---------------------------------------------------------------------------
module cv32e40p_hwlp_unit #(
    parameter int N_HWLP      = 2,
    parameter int N_HWLP_BITS = (N_HWLP > 1) ? $clog2(N_HWLP) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2:0]                    we_i,
    input  logic [N_HWLP_BITS-1:0]        regid_i,
    input  logic [31:0]                   wdata_i,
    input  logic [31:0]                   pc_id_i,
    input  logic                          id_valid_i,
    input  logic                          jump_ack_i,
    output logic                          jump_o,
    output logic [31:0]                   target_o,
    output logic                          stall_o,
    output logic [N_HWLP-1:0][31:0]       start_o,
    output logic [N_HWLP-1:0][31:0]       end_o,
    output logic [N_HWLP-1:0][31:0]       cnt_o,
    output logic                          err_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [31:0]               target_q, target_d;
    logic [N_HWLP-1:0][31:0]   start_q, start_d;
    logic [N_HWLP-1:0][31:0]   end_q, end_d;
    logic [N_HWLP-1:0][31:0]   cnt_q, cnt_d;
    logic [N_HWLP-1:0]         hit;
    logic                      sel_valid;
    logic [N_HWLP_BITS-1:0]    sel_idx;
    logic                      collide;

    // Raw hit per loop; no hits are evaluated while a jump is pending.
    always_comb begin
        for (int i = 0; i < N_HWLP; i++) begin
            hit[i] = id_valid_i && (pc_id_i == end_q[i]) && (cnt_q[i] != 32'd0)
                     && (state_q == IDLE);
        end
    end

    // Lowest index wins so that the innermost loop is serviced first.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < N_HWLP; i++) begin
            if (!sel_valid && hit[i]) begin
                sel_valid = 1'b1;
                sel_idx   = N_HWLP_BITS'(i);
            end
        end
    end

    // A count write to the loop being serviced overrides the decrement and
    // cancels its jump; the hit is simply dropped, not passed to another loop.
    assign collide = we_i[2] && (regid_i == sel_idx);

    // Next-state for the register file, state machine and latched target.
    // Start/end writes only land in *_d, so matching and target capture in the
    // current cycle always see the old register values.
    always_comb begin
        start_d  = start_q;
        end_d    = end_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        target_d = target_q;

        if (sel_valid && !collide) begin
            cnt_d[sel_idx] = cnt_q[sel_idx] - 32'd1;
            if (cnt_q[sel_idx] > 32'd1) begin
                state_d  = PEND;
                target_d = start_q[sel_idx];
            end
        end

        for (int i = 0; i < N_HWLP; i++) begin
            if (regid_i == N_HWLP_BITS'(i)) begin
                if (we_i[0]) start_d[i] = {wdata_i[31:1], 1'b0};
                if (we_i[1]) end_d[i]   = {wdata_i[31:1], 1'b0};
                if (we_i[2]) cnt_d[i]   = wdata_i;
            end
        end

        if (state_q == PEND && jump_ack_i) begin
            state_d = IDLE;
        end
    end

    // State, target and loop registers; reset clears everything so a reset
    // during a pending jump drops jump_o immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            start_q  <= '0;
            end_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            start_q  <= start_d;
            end_q    <= end_d;
            cnt_q    <= cnt_d;
        end
    end

    assign jump_o   = (state_q == PEND);
    assign stall_o  = jump_o;
    assign target_o = target_q;
    assign start_o  = start_q;
    assign end_o    = end_q;
    assign cnt_o    = cnt_q;

`ifdef CV32E40P_HWLP_ERR_CHECK_EN
    logic err_q;
    logic err_set;
    logic err_clr;

    // Bounds are checked against post-write values so a start/end write in the
    // same cycle as the count write is taken into account. Nesting is flagged
    // when loop 1 hits while an active loop 0 ends beyond loop 1's end.
    always_comb begin
        err_set = 1'b0;
        err_clr = 1'b0;
        for (int i = 0; i < N_HWLP; i++) begin
            if (we_i[2] && regid_i == N_HWLP_BITS'(i)) begin
                if (wdata_i != 32'd0 && end_d[i] <= start_d[i]) err_set = 1'b1;
                if (wdata_i == 32'd0) err_clr = 1'b1;
            end
        end
        for (int i = 1; i < N_HWLP; i++) begin
            if (i == 1 && hit[i] && cnt_q[0] != 32'd0 && end_q[0] > end_q[i]) begin
                err_set = 1'b1;
            end
        end
    end

    // Sticky error flag; setting takes precedence over clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/cv32e40p_hwlp_unit.md
# cv32e40p_hwlp_unit

Hardware-loop unit for CV32E40P. It holds the start, end and count registers for N_HWLP zero-overhead loops and watches the ID-stage PC for loop-end hits. On each hit it decrements the loop count and issues a registered branch-to-start request to the prefetcher, holding that request until the prefetcher accepts it. It sits between the ID stage, which supplies the PC, retire strobe and lp.* writes, and the IF/prefetch stage, which consumes the jump request.

## Interface
Parameters:
- N_HWLP, 2, number of hardware loops; loop 0 is the innermost loop and has highest priority.
- N_HWLP_BITS, $clog2(N_HWLP), width of the loop index; the minimum is 1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- we_i  in  3  write strobes: bit0 start, bit1 end, bit2 count.
- regid_i  in  N_HWLP_BITS  index of the loop being written.
- wdata_i  in  32  write data.
- pc_id_i  in  32  PC of the instruction in ID.
- id_valid_i  in  1  the ID instruction retires this cycle.
- jump_ack_i  in  1  prefetcher accepts the pending jump.
- jump_o  out  1  a loop-back jump is pending.
- target_o  out  32  jump target (loop start).
- stall_o  out  1  ID must not advance; equals jump_o.
- start_o  out  N_HWLP×32  start registers, for CSR read.
- end_o  out  N_HWLP×32  end registers, for CSR read.
- cnt_o  out  N_HWLP×32  count registers, for CSR read.
- err_o  out  1  loop configuration error (see Configuration).

## Operation
- Per loop i, the unit holds start[i], end[i] and cnt[i], each 32 bits.
  - Writes to start and end force bit0 to 0.
  - A loop is active when cnt[i] != 0.
- **Hit detection:** hit[i] = id_valid_i && pc_id_i == end[i] && cnt[i] != 0 && !jump_o.
  - The selected loop is the lowest-indexed i with hit[i].
  - At most one loop is serviced per cycle. Non-selected loops are not decremented.
- **Service of the selected loop k:**
  - cnt[k] decrements by 1.
  - If the pre-decrement value is greater than 1, the unit enters state PEND and latches target_q = start[k].
  - If the value is exactly 1, cnt[k] becomes 0, no jump is issued and execution falls through.
- **Write rules:**
  - A write to cnt[regid_i] in the same cycle as a decrement of the same loop: the write wins and no jump is issued for that loop. The hit is dropped entirely; the next lower-priority hit is not substituted.
  - Writes to start or end in the same cycle as a hit use the old value for matching and for target latching. The new value takes effect the next cycle.
  - Writes are accepted in any state, including PEND.
- **State machine:**
  - IDLE: jump_o=0. On a service with pre-count > 1, go to PEND.
  - PEND: jump_o=1 and target_o=target_q, both stable. On jump_ack_i, go to IDLE in the next cycle. No new hits are evaluated while in PEND.
- **Arithmetic:** cnt is unsigned. A decrement from 0 cannot occur because a hit requires cnt != 0. Writing 0 deactivates the loop.

## Timing
- **Reset:** all start, end and cnt registers are 0; state is IDLE; jump_o=0, target_o=0, stall_o=0, err_o=0.
- **Jump latency:** a hit at edge N causes jump_o=1 from edge N+1. The count update is also visible on cnt_o from edge N+1.
- **Handshake:** jump_o stays high until a cycle in which jump_ack_i=1. It falls at the following edge.
  - jump_ack_i while in IDLE is ignored.
  - An acknowledge in the first PEND cycle is legal, giving a minimum one-cycle pulse.
- **Write timing:** write data is visible on start_o, end_o and cnt_o one cycle after the strobe.
- **Reset mid-operation:** asserting rst_n=0 during PEND drops jump_o asynchronously and clears all counts.

## Configuration
- Macro: CV32E40P_HWLP_ERR_CHECK_EN.
- **Defined:**
  - err_o is set at the edge after a nonzero write to cnt[j] while end[j] <= start[j], compared unsigned using the post-write register values.
  - err_o is also set when a hit occurs on loop 1 while loop 0 is active and end[0] > end[1] (improper nesting).
  - err_o is sticky and is cleared only by reset or by a write of 0 to any cnt register.
  - Loop behaviour is otherwise unchanged.
- **Not defined:** err_o is tied to 0 and no checking logic is synthesised.

## Test plan
- **Basic loop:** start0=0x100, end0=0x10C, cnt0=3; retire at pc 0x10C three times, acknowledging each jump.
  - Expect two jumps with target_o=0x100, then fall-through.
  - cnt0 steps 3→2→1→0.
- **Nested priority:** loop0 0x200–0x208 with cnt 2; loop1 0x1F0–0x208 with cnt 2; retire at 0x208.
  - Only loop0 decrements; target_o=0x200.
  - At the next hit, loop0 reaches 0 and falls through; at the hit after that, loop1 jumps to 0x1F0.
- **Handshake hold:** hit with cnt=5 and jump_ack_i held low for 4 cycles.
  - jump_o and target_o stay stable and stall_o=1 throughout.
  - A retire at end0 during PEND causes no decrement.
- **Collision:** write cnt0=7 in the same cycle as a loop-0 hit with cnt0=4.
  - Next cycle cnt0=7 and jump_o=0.
- **Reset mid-PEND:** drive rst_n low while jump_o=1.
  - jump_o=0 immediately; after release all counts read 0.
- **Error check (macro defined):** start1=0x300, end1=0x300, cnt1=1.
  - err_o=1 next cycle; writing cnt0=0 clears it.
